// File: rtl/dwa_element_selector.sv
// DWA unit-element selector: turns a quantizer level into a mask of `level`
// consecutive elements starting at a rotating pointer. A single output register
// sits behind a valid/ready handshake, and ready passes straight through.
module dwa_element_selector #(
    parameter int unsigned NUM_ELEM    = 16,
    parameter int unsigned LEVEL_WIDTH = 5,
    parameter int unsigned PTR_WIDTH   = $clog2(NUM_ELEM)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [LEVEL_WIDTH-1:0] level_i,
    input  logic                   level_valid_i,
    output logic                   level_ready_o,
    input  logic                   dwa_en_i,
    output logic [NUM_ELEM-1:0]    sel_o,
    output logic                   sel_valid_o,
    input  logic                   sel_ready_i,
    output logic                   sat_o,
    output logic [PTR_WIDTH-1:0]   ptr_o
);

    // Two spare bits so that ptr + L (both at most NUM_ELEM) cannot overflow.
    localparam int unsigned SumW = PTR_WIDTH + 2;

    typedef enum logic {StEmpty, StFull} state_e;

    state_e                 state_q, state_d;
    logic [NUM_ELEM-1:0]    sel_q, sel_d;
    logic                   sat_q, sat_d;
    logic [PTR_WIDTH-1:0]   ptr_q, ptr_d;

    logic                   accept;
    logic                   clip;
    logic [LEVEL_WIDTH-1:0] level_eff;
    logic [PTR_WIDTH-1:0]   base;
    logic [NUM_ELEM-1:0]    therm;
    logic [2*NUM_ELEM-1:0]  wide;
    logic [NUM_ELEM-1:0]    mask;
    logic [SumW-1:0]        sum;
    logic [PTR_WIDTH-1:0]   ptr_next;

    assign sel_valid_o   = (state_q == StFull);
    assign level_ready_o = !sel_valid_o || sel_ready_i;
    assign accept        = level_valid_i && level_ready_o;

    // Clip the level, build the rotated mask and the next pointer.
    always_comb begin
        clip      = level_i > LEVEL_WIDTH'(NUM_ELEM);
        level_eff = clip ? LEVEL_WIDTH'(NUM_ELEM) : level_i;
        // Static mode always anchors the thermometer at element 0.
        base      = dwa_en_i ? ptr_q : '0;
        therm     = '0;
        for (int unsigned k = 0; k < NUM_ELEM; k++) begin
            therm[k] = LEVEL_WIDTH'(k) < level_eff;
        end
        // Rotate left by base; bits shifted past the top fold back to element 0.
        wide = {{NUM_ELEM{1'b0}}, therm} << base;
        mask = wide[NUM_ELEM-1:0] | wide[2*NUM_ELEM-1:NUM_ELEM];
        sum  = SumW'(base) + SumW'(level_eff);
        if (!dwa_en_i) begin
            ptr_next = '0;
        end else if (sum >= SumW'(NUM_ELEM)) begin
            ptr_next = PTR_WIDTH'(sum - SumW'(NUM_ELEM));
        end else begin
            ptr_next = PTR_WIDTH'(sum);
        end
    end

    // Next-state: load on acceptance, empty on drain, otherwise hold.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        sat_d   = sat_q;
        ptr_d   = ptr_q;
        if (accept) begin
            state_d = StFull;
            sel_d   = mask;
            sat_d   = clip;
            ptr_d   = ptr_next;
        end else if (state_q == StFull && sel_ready_i) begin
            state_d = StEmpty;
        end
    end

    // State registers with synchronous reset; sel_o comes straight from a flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StEmpty;
            sel_q   <= '0;
            sat_q   <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            sat_q   <= sat_d;
            ptr_q   <= ptr_d;
        end
    end

    assign sel_o = sel_q;
    assign sat_o = sat_q;
    assign ptr_o = ptr_q;

endmodule

// File: tb/tb_dwa_element_selector.sv
// Bench for dwa_element_selector: a table of vectors, a few hand-written
// corner sequences and a randomised stream, all checked through a queue.
module tb_dwa_element_selector;

    localparam int unsigned N  = 16;
    localparam int unsigned LW = 5;
    localparam int unsigned PW = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [LW-1:0] level_i;
    logic          level_valid_i;
    logic          level_ready_o;
    logic          dwa_en_i;
    logic [N-1:0]  sel_o;
    logic          sel_valid_o;
    logic          sel_ready_i;
    logic          sat_o;
    logic [PW-1:0] ptr_o;

    dwa_element_selector #(
        .NUM_ELEM    (N),
        .LEVEL_WIDTH (LW),
        .PTR_WIDTH   (PW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .level_i       (level_i),
        .level_valid_i (level_valid_i),
        .level_ready_o (level_ready_o),
        .dwa_en_i      (dwa_en_i),
        .sel_o         (sel_o),
        .sel_valid_o   (sel_valid_o),
        .sel_ready_i   (sel_ready_i),
        .sat_o         (sat_o),
        .ptr_o         (ptr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  sel;
        logic          sat;
        logic [PW-1:0] ptr;
    } exp_t;

    typedef struct {
        logic [LW-1:0] level;
        logic          en;
        logic [N-1:0]  sel;
        logic          sat;
        logic [PW-1:0] ptr;
    } vec_t;

    exp_t q[$];
    vec_t tbl[10];
    int   checks = 0;
    int   errors = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Reference: mark each element individually, modulo N.
    function automatic exp_t model(input logic [LW-1:0] lvl, input logic en,
                                   input logic [PW-1:0] p);
        exp_t r;
        int   l;
        int   b;
        l = (int'(lvl) > N) ? N : int'(lvl);
        b = en ? int'(p) : 0;
        r.sel = '0;
        for (int j = 0; j < l; j++) r.sel[(b + j) % N] = 1'b1;
        r.sat = int'(lvl) > N;
        r.ptr = en ? PW'((b + l) % N) : '0;
        return r;
    endfunction

    // Scoreboard: compare every output that is popped downstream.
    always @(negedge clk) begin
        exp_t e;
        if (rst_i === 1'b0 && sel_valid_o === 1'b1 && sel_ready_i === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%0h required=none", sel_o);
            end else begin
                e = q.pop_front();
                chk("sb_sel", 32'(sel_o), 32'(e.sel));
                chk("sb_sat", 32'(sat_o), 32'(e.sat));
                chk("sb_ptr", 32'(ptr_o), 32'(e.ptr));
            end
        end
    end

    // Present a level just after a rising edge; push its expectation once accepted.
    task automatic send(input logic [LW-1:0] lvl, input logic en, input exp_t e,
                        input bit rnd, output int waited);
        bit acc = 1'b0;
        level_i       = lvl;
        dwa_en_i      = en;
        level_valid_i = 1'b1;
        waited        = 0;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            if (level_ready_o === 1'b1) begin
                q.push_back(e);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
            if (!acc) begin
                waited++;
                if (rnd) sel_ready_i = ($urandom_range(0, 3) != 0);
            end
        end
        level_valid_i = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=0 required=1");
        end
    endtask

    task automatic drain();
        sel_ready_i = 1'b1;
        for (int n = 0; n < 30 && q.size() != 0; n++) @(posedge clk);
        #1;
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int   w;
        exp_t e;
        logic [PW-1:0] mptr;
        logic [LW-1:0] lvl;
        logic          en;

        tbl[0] = '{5'd5,  1'b1, 16'h001F, 1'b0, 4'd5};
        tbl[1] = '{5'd7,  1'b1, 16'h0FE0, 1'b0, 4'd12};
        tbl[2] = '{5'd6,  1'b1, 16'hF003, 1'b0, 4'd2};
        tbl[3] = '{5'd20, 1'b1, 16'hFFFF, 1'b1, 4'd2};
        tbl[4] = '{5'd16, 1'b1, 16'hFFFF, 1'b0, 4'd2};
        tbl[5] = '{5'd0,  1'b1, 16'h0000, 1'b0, 4'd2};
        tbl[6] = '{5'd7,  1'b1, 16'h01FC, 1'b0, 4'd9};
        tbl[7] = '{5'd3,  1'b0, 16'h0007, 1'b0, 4'd0};
        tbl[8] = '{5'd2,  1'b1, 16'h0003, 1'b0, 4'd2};
        tbl[9] = '{5'd14, 1'b1, 16'hFFFC, 1'b0, 4'd0};

        // Reset held for two edges with a level offered.
        rst_i         = 1'b1;
        level_valid_i = 1'b1;
        level_i       = 5'd9;
        dwa_en_i      = 1'b1;
        sel_ready_i   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(sel_valid_o), 32'd0);
        chk("rst_sel",   32'(sel_o),       32'd0);
        chk("rst_ptr",   32'(ptr_o),       32'd0);
        chk("rst_sat",   32'(sat_o),       32'd0);
        @(posedge clk);
        #1;
        rst_i         = 1'b0;
        level_valid_i = 1'b0;
        #1;
        chk("rst_ready", 32'(level_ready_o), 32'd1);

        // Back-to-back table vectors: each must be accepted on its first cycle.
        for (int i = 0; i < 10; i++) begin
            e.sel = tbl[i].sel;
            e.sat = tbl[i].sat;
            e.ptr = tbl[i].ptr;
            send(tbl[i].level, tbl[i].en, e, 1'b0, w);
            chk("tbl_no_stall", 32'(w), 32'd0);
        end
        // The last table entry must be visible with no bubble after its acceptance.
        @(negedge clk);
        chk("tbl_last_valid", 32'(sel_valid_o), 32'd1);
        drain();
        @(negedge clk);
        chk("drained_valid", 32'(sel_valid_o), 32'd0);
        @(posedge clk);
        #1;

        // Backpressure: hold 0x0007 for three cycles while level 4 waits.
        send(5'd3, 1'b1, '{16'h0007, 1'b0, 4'd3}, 1'b0, w);
        sel_ready_i   = 1'b0;
        level_i       = 5'd4;
        level_valid_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_ready", 32'(level_ready_o), 32'd0);
            chk("bp_sel",   32'(sel_o),         32'h0007);
            chk("bp_valid", 32'(sel_valid_o),   32'd1);
            @(posedge clk);
            #1;
        end
        sel_ready_i = 1'b1;
        send(5'd4, 1'b1, '{16'h0078, 1'b0, 4'd7}, 1'b0, w);
        chk("bp_release_accept", 32'(w), 32'd0);
        @(negedge clk);
        chk("bp_no_bubble", 32'(sel_valid_o), 32'd1);
        chk("bp_new_sel",   32'(sel_o),       32'h0078);
        @(posedge clk);
        #1;

        // Random stream with random backpressure against the element-wise model.
        mptr = 4'd7;
        for (int i = 0; i < 40; i++) begin
            lvl = LW'($urandom_range(0, 20));
            en  = ($urandom_range(0, 4) != 0);
            e   = model(lvl, en, mptr);
            mptr = e.ptr;
            sel_ready_i = ($urandom_range(0, 3) != 0);
            send(lvl, en, e, 1'b1, w);
        end
        drain();
        @(posedge clk);
        #1;

        // Reset mid-stream with ptr at 11 and an output held.
        send(5'd0, 1'b0, '{16'h0000, 1'b0, 4'd0}, 1'b0, w);
        send(5'd11, 1'b1, '{16'h07FF, 1'b0, 4'd11}, 1'b0, w);
        sel_ready_i = 1'b0;
        @(negedge clk);
        chk("mid_valid_before", 32'(sel_valid_o), 32'd1);
        chk("mid_ptr_before",   32'(ptr_o),       32'd11);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        q.delete();
        @(negedge clk);
        chk("mid_valid_after", 32'(sel_valid_o), 32'd0);
        chk("mid_ptr_after",   32'(ptr_o),       32'd0);
        @(posedge clk);
        #1;
        sel_ready_i = 1'b1;
        send(5'd3, 1'b1, '{16'h0007, 1'b0, 4'd3}, 1'b0, w);
        @(negedge clk);
        chk("post_rst_sel", 32'(sel_o), 32'h0007);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
